rs232_avm_slave: RTL and testbench

//  Avalon-MM slave UART serving the RSA wrapper's polled byte bus: RX data @0x0, TX data @0x4, STATUS @0x8.

---
 rtl/rs232_pkg.sv | 50 +++++
 rtl/rs232_avm_slave_byte_fifo.sv | 71 +++++++
 rtl/rs232_avm_slave.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_rs232_avm_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS-232 Avalon-MM slave.
//   - Register byte addresses on the 5-bit Avalon address bus.
//   - Bit positions inside the STATUS word.
//   - TX and RX state enumerations.
//   - status_word(): packs the STATUS flags into a 32-bit read word.
// ---------------------------------------------------------------------------
package rs232_pkg;

    localparam logic [4:0] RX_BASE     = 5'h00;
    localparam logic [4:0] TX_BASE     = 5'h04;
    localparam logic [4:0] STATUS_BASE = 5'h08;

    localparam int RX_OK_BIT     = 7;
    localparam int TX_OK_BIT     = 6;
    localparam int FRAME_ERR_BIT = 1;
    localparam int OVERRUN_BIT   = 0;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    // Every bit that is not a named flag reads as zero.
    function automatic logic [31:0] status_word(
        input logic rx_ok,
        input logic tx_ok,
        input logic frame_err,
        input logic overrun
    );
        logic [31:0] w;
        w                = '0;
        w[RX_OK_BIT]     = rx_ok;
        w[TX_OK_BIT]     = tx_ok;
        w[FRAME_ERR_BIT] = frame_err;
        w[OVERRUN_BIT]   = overrun;
        return w;
    endfunction

endpackage

// File: rtl/rs232_avm_slave_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small synchronous byte FIFO. It is used once for RX and once for TX.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   push, push_data  write request and data.
//                    A push into a full FIFO is dropped, unless a pop
//                    happens in the same cycle.
//   pop              read request. It is ignored when the FIFO is empty.
//   head             oldest entry. It is valid while empty is low.
//   empty, full      fill-level flags
// A push and a pop may happen in the same cycle at any fill level.
// When the FIFO is full, a simultaneous push and pop leave it full.
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A slot freed by a pop in the same cycle can take the new byte.
        do_push  = push & (~full | do_pop);
        // DEPTH is a power of two, so the pointers wrap on their own.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array has no reset. Entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rs232_avm_slave.sv
// ---------------------------------------------------------------------------
// rs232_avm_slave
// Avalon-MM slave UART with polled byte registers. Frames are 8N1, LSB first.
// Register map:
//   RX at 0x0
//   TX at 0x4
//   STATUS at 0x8
// Ports:
//   avm_clk, avm_rst_n   clock and asynchronous active-low reset
//   avm_address          byte address
//   avm_read, avm_write  requests. The master holds each one until it is accepted.
//   avm_writedata        bits [7:0] carry the TX byte
//   avm_readdata         registered read data
//   avm_waitrequest      stall. Every access gets exactly one wait state.
//   uart_rxd             asynchronous serial input, idle high
//   uart_txd             registered serial output, idle high
// ---------------------------------------------------------------------------
module rs232_avm_slave
    import rs232_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic [31:0] avm_readdata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    // ---------------- bus registers ----------------
    logic        ack_q, ack_d;
    logic [31:0] readdata_q, readdata_d;
    logic        rx_snap_q, rx_snap_d;    // the RX read snapshot held a real byte
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    // ---------------- TX engine ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;

    // ---------------- RX engine ----------------
    logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;

    // ---------------- FIFO handshakes ----------------
    logic       rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0] rx_head;
    logic       tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0] tx_head;

    logic        req, accept, st_clear, fe_set, ov_set;
    logic [31:0] rd_mux;
    logic        tx_last, rx_last, rx_half;
    logic        rx_fall;
    logic [23:0] unused_writedata;

    assign unused_writedata = avm_writedata[31:8];

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (avm_clk),
        .rst_n     (avm_rst_n),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (avm_clk),
        .rst_n     (avm_rst_n),
        .push      (tx_push),
        .push_data (avm_writedata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    assign avm_readdata = readdata_q;
    assign uart_txd     = txd_q;

    // ---------------- bus decode ----------------
    // In the first request cycle, ack is set and the read word is snapshotted.
    // In the second cycle (the accept cycle), the master proceeds and side effects happen.
    always_comb begin
        req             = avm_read | avm_write;
        accept          = req & ack_q;
        avm_waitrequest = req & ~ack_q;
        ack_d           = req & ~ack_q;

        unique case (avm_address)
            RX_BASE:     rd_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
            STATUS_BASE: rd_mux = status_word(~rx_empty, ~tx_full, frame_err_q, overrun_q);
            default:     rd_mux = 32'd0;
        endcase

        readdata_d = readdata_q;
        rx_snap_d  = rx_snap_q;
        if (avm_read && !ack_q) begin
            readdata_d = rd_mux;
            rx_snap_d  = (avm_address == RX_BASE) & ~rx_empty;
        end

        // A pop follows the snapshot.
        // A byte that arrives between the wait cycle and the accept cycle is not lost.
        rx_pop   = accept & avm_read & (avm_address == RX_BASE) & rx_snap_q;
        st_clear = accept & avm_read & (avm_address == STATUS_BASE);
        tx_push  = accept & avm_write & (avm_address == TX_BASE);
    end

    // ---------------- TX FSM ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        tx_last    = (tx_cnt_q == CNT_W'(DIV - 1));

        unique case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = T_START;
                    txd_d      = 1'b0;
                end
            end
            T_START: begin
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = T_DATA;
                    txd_d      = tx_shift_q[0];
                end
            end
            T_DATA: begin
                if (tx_last) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = T_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            T_STOP: begin
                if (tx_last) begin
                    tx_cnt_d = '0;
                    // Load the next byte straight from the stop bit.
                    // This leaves no idle gap between frames.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = T_START;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = T_IDLE;
                        txd_d      = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = T_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // ---------------- RX FSM ----------------
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        ov_set     = 1'b0;
        rx_fall    = rx_prev_q & ~rx_sync2_q;
        rx_last    = (rx_cnt_q == CNT_W'(DIV - 1));
        rx_half    = (rx_cnt_q == CNT_W'(HALF - 1));

        unique case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = R_START;
                end
            end
            R_START: begin
                // At mid start bit, a high line means the edge was a glitch.
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            R_STOP: begin
                if (rx_last) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    if (!rx_sync2_q) begin
                        fe_set = 1'b1;
                    end else if (!rx_full || rx_pop) begin
                        rx_push = 1'b1;
                    end else begin
                        ov_set = 1'b1;
                    end
                end
            end
            default: rx_state_d = R_IDLE;
        endcase

        // When a set event and a clear happen together, the set event takes priority.
        frame_err_d = fe_set | (frame_err_q & ~st_clear);
        overrun_d   = ov_set | (overrun_q & ~st_clear);
    end

    // ---------------- state registers ----------------
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            ack_q       <= 1'b0;
            readdata_q  <= '0;
            rx_snap_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_state_q  <= T_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= 1'b1;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            ack_q       <= ack_d;
            readdata_q  <= readdata_d;
            rx_snap_q   <= rx_snap_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            rx_sync1_q  <= uart_rxd;
            rx_sync2_q  <= rx_sync1_q;
            rx_prev_q   <= rx_sync2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// ---------------------------------------------------------------------------
// tb_rs232_avm_slave
// Directed bench for rs232_avm_slave at CLK_HZ=160 and BAUD=10, giving 16 clocks per bit.
// Each read queues its expected word on a scoreboard.
// A monitor pops the scoreboard and compares whenever a read is accepted.
// TX frames are checked bit by bit against a reference waveform.
// ---------------------------------------------------------------------------
module tb_rs232_avm_slave;
    import rs232_pkg::*;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  avm_address = '0;
    logic        avm_read = 1'b0;
    logic        avm_write = 1'b0;
    logic [31:0] avm_writedata = '0;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    always #5 clk = ~clk;

    rs232_avm_slave #(.CLK_HZ(160), .BAUD(10), .FIFO_DEPTH(4)) dut (
        .avm_clk         (clk),
        .avm_rst_n       (rst_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    typedef struct {
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Compare read data in every accept cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && avm_read && !avm_waitrequest) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: actual=0x%08h required=none", avm_readdata);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, avm_readdata, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for the accept cycle. Expect exactly one wait state.
    task automatic wait_accept(input string name);
        int waits;
        waits = 0;
        @(negedge clk);
        while (avm_waitrequest && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        avm_read  = 1'b0;
        avm_write = 1'b0;
        check({name, "_waits"}, 32'(waits), 32'd1);
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.data = exp;
        e.name = name;
        sb_q.push_back(e);
        avm_address = addr;
        avm_read    = 1'b1;
        wait_accept(name);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [7:0] b, input string name);
        avm_address   = addr;
        avm_writedata = {24'hABCDEF, b};
        avm_write     = 1'b1;
        wait_accept(name);
    endtask

    // Drive one frame onto rxd, 16 clocks per bit. stop_v sets the stop-bit level.
    task automatic rx_frame(input logic [7:0] b, input logic stop_v);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = f[k];
            cyc(DIV);
        end
        uart_rxd = 1'b1;
    endtask

    // Check a TX frame bit by bit. The reported value is the count of matching clocks per bit.
    // In contiguous mode, the start bit must follow the previous stop bit directly.
    task automatic check_tx_frame(input logic [7:0] b, input bit contiguous, input string name);
        logic [9:0] f;
        int good, n;
        f = {1'b1, b, 1'b0};
        n = 0;
        if (!contiguous) begin
            @(negedge clk);
            while (uart_txd !== 1'b0 && n < 400) begin
                n++;
                @(negedge clk);
            end
        end
        for (int k = 0; k < 10; k++) begin
            good = 0;
            for (int j = 0; j < DIV; j++) begin
                if (contiguous || k != 0 || j != 0) @(negedge clk);
                if (uart_txd === f[k]) good++;
            end
            check($sformatf("%s_bit%0d", name, k), 32'(good), 32'(DIV));
        end
    endtask

    task automatic check_idle(input int n, input string name);
        int high;
        high = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_txd === 1'b1) high++;
        end
        check(name, 32'(high), 32'(n));
    endtask

    logic [7:0] burst [5];
    logic [7:0] rxb   [5];

    initial begin
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rxb   = '{8'h01, 8'h02, 8'h80, 8'hFE, 8'h5A};

        // Reset state
        cyc(3);
        @(negedge clk);
        check("rst_readdata", avm_readdata, 32'd0);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_waitreq", {31'd0, avm_waitrequest}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        bus_read(STATUS_BASE, 32'h40, "st_after_reset");

        // RX byte 0xA5
        rx_frame(8'hA5, 1'b1);
        cyc(4);
        bus_read(STATUS_BASE, 32'hC0, "st_rx_a5");
        bus_read(RX_BASE, 32'hA5, "rx_a5");
        bus_read(STATUS_BASE, 32'h40, "st_rx_drained");
        bus_read(5'h04, 32'h0, "rd_tx_addr");
        bus_read(5'h1C, 32'h0, "rd_unmapped");

        // Single TX byte 0x3C
        fork
            bus_write(TX_BASE, 8'h3C, "wr_3c");
            check_tx_frame(8'h3C, 1'b0, "tx_3c");
        join
        check_idle(20, "tx_idle_after_3c");

        // Five bytes with no drain. A sixth write is dropped.
        cyc(1);
        fork
            begin
                for (int i = 0; i < 5; i++) bus_write(TX_BASE, burst[i], $sformatf("wr_burst%0d", i));
                bus_read(STATUS_BASE, 32'h00, "st_tx_full");
                bus_write(TX_BASE, 8'h66, "wr_dropped");
            end
            begin
                check_tx_frame(burst[0], 1'b0, "tx_burst0");
                for (int i = 1; i < 5; i++) check_tx_frame(burst[i], 1'b1, $sformatf("tx_burst%0d", i));
            end
        join
        check_idle(48, "tx_no_sixth_frame");
        cyc(1);
        bus_read(STATUS_BASE, 32'h40, "st_tx_drained");

        // Overrun
        for (int i = 0; i < 5; i++) rx_frame(rxb[i], 1'b1);
        cyc(4);
        bus_read(STATUS_BASE, 32'hC1, "st_overrun");
        for (int i = 0; i < 4; i++) bus_read(RX_BASE, {24'd0, rxb[i]}, $sformatf("rx_ovr%0d", i));
        bus_read(RX_BASE, 32'h0, "rx_empty_read");
        bus_read(STATUS_BASE, 32'h40, "st_overrun_cleared");

        // Framing error
        rx_frame(8'h55, 1'b0);
        cyc(8);
        bus_read(STATUS_BASE, 32'h42, "st_frame_err");
        bus_read(STATUS_BASE, 32'h40, "st_frame_err_cleared");
        bus_read(RX_BASE, 32'h0, "rx_no_push_on_ferr");

        // Reset during a TX frame
        bus_write(TX_BASE, 8'h00, "wr_00");
        cyc(40);
        @(negedge clk);
        check("txd_mid_frame", {31'd0, uart_txd}, 32'd0);
        cyc(1);
        rst_n = 1'b0;
        @(negedge clk);
        check("txd_reset_abort", {31'd0, uart_txd}, 32'd1);
        cyc(2);
        rst_n = 1'b1;
        check_idle(200, "tx_idle_after_reset");
        cyc(1);
        bus_read(STATUS_BASE, 32'h40, "st_after_mid_reset");

        cyc(5);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
